// File: rtl/width_gearbox.sv
// LSB-first bit-stream width converter: IN_W-bit words in, OUT_W-bit words out,
// with a flush that drains the residue as a zero-padded word tagged out_last.
//
// state | meaning
// RUN   | normal streaming; inputs accepted while fewer than OUT_W bits are held
// DRAIN | flush in progress; no inputs, residual bits popped, last word tagged
module width_gearbox #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 5,
  parameter int ACC_W = IN_W + OUT_W - 1,
  parameter int LVL_W = $clog2(ACC_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  input  logic             flush_req,
  output logic             flush_done,
  output logic [LVL_W-1:0] level
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam logic [LVL_W-1:0] OUT_CNT = LVL_W'(OUT_W);
  localparam logic [LVL_W-1:0] IN_CNT  = LVL_W'(IN_W);

  logic [ACC_W-1:0] acc, acc_next;
  logic [LVL_W-1:0] cnt, cnt_next;
  logic [0:0]       state, state_next;
  logic             push, pop;
  logic             flush_done_next;

  assign in_ready  = (state == RUN) && (cnt < OUT_CNT);
  assign out_valid = (cnt >= OUT_CNT) || ((state == DRAIN) && (cnt != '0));
  assign out_last  = (state == DRAIN) && (cnt <= OUT_CNT) && (cnt != '0);
  assign out_data  = acc[OUT_W-1:0];
  assign level     = cnt;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Push and pop never coincide: in RUN they need opposite cnt ranges, in DRAIN in_ready is 0.
  always_comb begin
    acc_next = acc;
    cnt_next = cnt;
    if (push) begin
      acc_next = acc | (ACC_W'(in_data) << cnt);
      cnt_next = cnt + IN_CNT;
    end else if (pop) begin
      acc_next = acc >> OUT_W;
      cnt_next = (cnt >= OUT_CNT) ? (cnt - OUT_CNT) : '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush_req) state_next = DRAIN;
      DRAIN:   if ((cnt == '0) || (pop && out_last)) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign flush_done_next = (state == DRAIN) && (state_next == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      acc        <= acc_next;
      cnt        <= cnt_next;
      state      <= state_next;
      flush_done <= flush_done_next;
    end
  end

endmodule

// File: tb/tb_width_gearbox.sv
// Scoreboard bench for width_gearbox: an 8->5 instance with directed vectors and
// a 5->8 instance checked against a bit-queue model.
module tb_width_gearbox;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // 8 -> 5 instance
  logic [7:0] a_in_data = '0;
  logic       a_in_valid = 1'b0, a_in_ready;
  logic [4:0] a_out_data;
  logic       a_out_valid, a_out_ready = 1'b0, a_out_last;
  logic       a_flush_req = 1'b0, a_flush_done;
  logic [3:0] a_level;

  width_gearbox #(.IN_W(8), .OUT_W(5)) ua (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_last(a_out_last), .flush_req(a_flush_req), .flush_done(a_flush_done),
    .level(a_level)
  );

  // 5 -> 8 instance
  logic [4:0] b_in_data = '0;
  logic       b_in_valid = 1'b0, b_in_ready;
  logic [7:0] b_out_data;
  logic       b_out_valid, b_out_ready = 1'b0, b_out_last;
  logic       b_flush_req = 1'b0, b_flush_done;
  logic [3:0] b_level;

  width_gearbox #(.IN_W(5), .OUT_W(8)) ub (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_last(b_out_last), .flush_req(b_flush_req), .flush_done(b_flush_done),
    .level(b_level)
  );

  // Scoreboard for A: {last, data}
  logic [5:0] exp_q[$];
  logic [5:0] a_exp;
  int         fd_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && a_flush_done) fd_cnt++;
    if (rst_n && a_out_valid && a_out_ready) begin
      check("a_word_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        a_exp = exp_q.pop_front();
        check("a_out_data", a_out_data, a_exp[4:0]);
        check("a_out_last", a_out_last, a_exp[5]);
      end
    end
  end

  // Bit-queue model for B
  bit         bitq[$];
  logic       b_flushing = 1'b0;
  logic       b_rand = 1'b0;
  logic [7:0] b_exp;
  logic       b_exp_last;

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      check("b_bits_available", bitq.size() > 0, 1);
      b_exp_last = b_flushing && (bitq.size() <= 8);
      b_exp = '0;
      for (int i = 0; i < 8; i++)
        if (bitq.size() > 0) b_exp[i] = bitq.pop_front();
      check("b_out_data", b_out_data, b_exp);
      check("b_out_last", b_out_last, b_exp_last);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (b_rand) b_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_a(input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    a_in_data = d;
    a_in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = a_in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    a_in_valid = 1'b0;
    check("a_push_accepted", ok, 1);
  endtask

  task automatic push_b(input logic [4:0] d);
    logic ok;
    ok = 1'b0;
    b_in_data = d;
    b_in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = b_in_ready;
      if (ok) for (int k = 0; k < 5; k++) bitq.push_back(d[k]);
      @(posedge clk);
      #1;
      if (ok) break;
    end
    b_in_valid = 1'b0;
    check("b_push_accepted", ok, 1);
  endtask

  task automatic pulse_flush_a();
    a_flush_req = 1'b1;
    @(posedge clk);
    #1;
    a_flush_req = 1'b0;
  endtask

  task automatic wait_drain_a();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("a_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic one_pop_a();
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
  endtask

  initial begin
    logic seen;

    // Reset, no traffic
    #2 rst_n = 1'b0;
    #10;
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_level", a_level, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_last", a_out_last, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_in_ready", a_in_ready, 1);
    check("idle_out_valid", a_out_valid, 0);
    check("idle_level", a_level, 0);

    // 8->5 stream: 0xA5, 0x3C -> 05, 05, 0F
    a_out_ready = 1'b1;
    exp_q.push_back({1'b0, 5'h05});
    exp_q.push_back({1'b0, 5'h05});
    exp_q.push_back({1'b0, 5'h0F});
    push_a(8'hA5);
    push_a(8'h3C);
    wait_drain_a();
    check("stream_level", a_level, 1);

    // Flush with one residual bit (0)
    fd_cnt = 0;
    exp_q.push_back({1'b1, 5'h00});
    pulse_flush_a();
    wait_drain_a();
    repeat (3) @(posedge clk);
    #1;
    check("flush_done_count", fd_cnt, 1);
    check("flush_level", a_level, 0);
    check("flush_in_ready", a_in_ready, 1);

    // Flush when empty: flush_done exactly two cycles later
    a_flush_req = 1'b1;
    @(negedge clk);
    check("empty_fd_c0", a_flush_done, 0);
    @(posedge clk);
    #1 a_flush_req = 1'b0;
    @(negedge clk);
    check("empty_fd_c1", a_flush_done, 0);
    check("empty_no_word", a_out_valid, 0);
    @(negedge clk);
    check("empty_fd_c2", a_flush_done, 1);
    @(negedge clk);
    check("empty_fd_c3", a_flush_done, 0);
    @(posedge clk);
    #1;

    // Backpressure
    a_out_ready = 1'b0;
    exp_q.push_back({1'b0, 5'h05});
    exp_q.push_back({1'b0, 5'h05});
    exp_q.push_back({1'b0, 5'h0F});
    push_a(8'hA5);
    a_in_data = 8'h3C;
    a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_data", a_out_data, 5'h05);
      check("bp_out_valid", a_out_valid, 1);
      check("bp_in_ready", a_in_ready, 0);
      check("bp_level", a_level, 8);
    end
    @(posedge clk);
    #1 a_out_ready = 1'b1;
    push_a(8'h3C);
    wait_drain_a();
    check("bp_end_level", a_level, 1);
    exp_q.push_back({1'b1, 5'h00});
    pulse_flush_a();
    wait_drain_a();
    check("bp_flush_level", a_level, 0);

    // Build level 6, then async reset mid-cycle
    a_out_ready = 1'b0;
    exp_q.push_back({1'b0, 5'h05});
    exp_q.push_back({1'b0, 5'h05});
    push_a(8'hA5);
    one_pop_a();
    push_a(8'h3C);
    one_pop_a();
    check("pre_rst_level", a_level, 6);
    check("pre_rst_valid", a_out_valid, 1);
    check("pre_rst_queue", exp_q.size(), 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", a_out_valid, 0);
    check("async_rst_level", a_level, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 5->8 random traffic against the bit queue, then flush the residue
    b_rand = 1'b1;
    for (int w = 0; w < 23; w++) push_b(5'($urandom_range(0, 31)));
    b_rand = 1'b0;
    b_out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!b_out_valid) break;
    end
    check("b_idle_before_flush", b_out_valid, 0);
    @(posedge clk);
    #1;
    b_flushing = 1'b1;
    b_flush_req = 1'b1;
    @(posedge clk);
    #1 b_flush_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_flush_done) begin
        seen = 1'b1;
        break;
      end
    end
    b_flushing = 1'b0;
    check("b_flush_done_seen", seen, 1);
    check("b_bitq_empty", bitq.size(), 0);
    check("b_level_zero", b_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/width_gearbox.md
# width_gearbox

- Parametrised LSB-first bit-stream width converter.
- Accepts IN_W-bit words on a valid/ready input port and emits OUT_W-bit words on a valid/ready output port; bit order is preserved across word boundaries.
- Supports a flush request that drains all residual bits, zero-pads the final partial word, and marks it with out_last.
- Sits between a byte-wide source and the symbol mapper; generalises the fixed 8-to-5 modulator front end.

## Interface

Parameters:
- IN_W, default 8: input word width, 1..32.
- OUT_W, default 5: output word width, 1..32.
- ACC_W, default IN_W+OUT_W-1: accumulator width (derived, not overridden).
- LVL_W, default $clog2(ACC_W+1): width of the level output.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- in_data  input  IN_W  input word; bit 0 is the first bit in time.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  OUT_W  output word; bit 0 is the first bit in time.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_last  output  1  qualifies the final word of a flush; meaningful only with out_valid.
- flush_req  input  1  request to drain residual bits.
- flush_done  output  1  one-cycle pulse when a flush completes.
- level  output  LVL_W  number of valid bits held (cnt).

## Operation

**State**
- acc[ACC_W-1:0] holds the bit buffer; bits at index ≥ cnt are always 0.
- cnt holds the number of valid bits.
- FSM has two states: RUN and DRAIN.

**Handshake signals**
- in_ready = (state==RUN) && (cnt < OUT_W). Derived from registered state only.
- out_valid = (cnt ≥ OUT_W) || (state==DRAIN && cnt > 0).
- out_data = acc[OUT_W-1:0]. Zero padding is automatic because bits above cnt are 0.
- out_last = (state==DRAIN) && (cnt ≤ OUT_W) && (cnt > 0).

**Push and pop**
- Push (in_valid && in_ready): acc |= in_data << cnt; cnt += IN_W.
- Pop (out_valid && out_ready): acc >>= OUT_W (zero fill); cnt = max(cnt-OUT_W, 0).
- Push and pop are mutually exclusive by construction:
  - Outside DRAIN, in_ready needs cnt<OUT_W, while out_valid needs cnt≥OUT_W.
  - In DRAIN, in_ready is 0.
- in_valid while in_ready=0: the word is held by the source. No data is lost or duplicated.

**Flush**
- In RUN, flush_req=1 moves the FSM to DRAIN on the next edge. A push in that same cycle still completes.
- In DRAIN, full words pop normally. The pop that brings cnt to 0 carries out_last=1.
- The FSM returns to RUN on the out_last pop, or immediately (next edge) if DRAIN is entered with cnt==0.
- flush_done pulses high for exactly one cycle, in the cycle after the return to RUN.
- flush_req is ignored in DRAIN.

## Timing

- Reset values: acc=0, cnt=0, state=RUN, flush_done=0.
- Output values during and after reset: out_valid=0, out_last=0, out_data=0, level=0, in_ready=1.
- Assertion of rst_n low mid-operation discards all buffered bits immediately (asynchronous). No output word is emitted for them.
- Latency: an accepted word makes out_valid visible the cycle after acceptance, provided cnt+IN_W ≥ OUT_W.
- Steady-state throughput:
  - With IN_W > OUT_W, one output word per cycle while cnt ≥ OUT_W, and one input per refill cycle.
  - 8→5 sustains 8 bits per 13/5 cycles, i.e. a pattern of 1 input then 1–2 outputs.
- Outputs hold stable while out_valid && !out_ready.
- Width rules: acc never exceeds ACC_W. The maximum cnt is OUT_W-1+IN_W = ACC_W.

## Test plan

- **Reset, no traffic:** rst_n low then high, no stimulus → in_ready=1, out_valid=0, level=0.
- **8→5 stream:** push 0xA5 then 0x3C, out_ready=1 → outputs 0x05, 0x05, 0x0F with out_last=0; level ends at 1.
- **Flush with residue:** after the previous scenario, pulse flush_req → one word 0x00 with out_last=1, then flush_done pulses once, level=0, in_ready=1 again.
- **Flush when empty:** flush_req with cnt=0 → no output word; flush_done pulses exactly once, 2 cycles after flush_req.
- **Backpressure:** out_ready=0 for 5 cycles while in_valid=1 with IN_W=8, OUT_W=5 → out_data is stable, in_ready=0, no extra pushes; on release, the output sequence equals the unstalled reference.
- **Mid-stream reset, then reparametrise:** assert rst_n low with level=6 → out_valid drops asynchronously and level=0. Then run IN_W=5, OUT_W=8 with random data against a bit-queue model → bit-exact match.
